cmos_dvp_capture: RTL

Parametrised DVP camera capture front end, successor to the fixed 8-bit/RGB565 decoder in the OV sensor path. Samples the sensor's parallel bus on its pixel clock, skips a configurable number of start-up frames, assembles 1- or 2-byte pixels with selectable byte order, crops to a per-frame-latched window, and emits a pixel stream with start-of-frame/end-of-line markers plus line-length and framing-error status for the downstream frame-buffer writer.

---
 rtl/cmos_dvp_capture_if.sv | 14 +
 rtl/cmos_dvp_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cmos_dvp_capture_if.sv
// Pixel stream leaving the DVP capture front end toward the frame-buffer writer.
// master = capture block (producer), slave = downstream consumer.
interface cmos_dvp_capture_if #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2
);
  logic                              pix_valid_o;
  logic [BYTES_PER_PIX*DATA_W-1:0]   pix_data_o;
  logic                              pix_sof_o;
  logic                              pix_eol_o;

  modport master (output pix_valid_o, pix_data_o, pix_sof_o, pix_eol_o);
  modport slave  (input  pix_valid_o, pix_data_o, pix_sof_o, pix_eol_o);
endinterface

// File: rtl/cmos_dvp_capture.sv
// DVP camera capture: registers the sensor bus, skips start-up frames, assembles
// 1/2-beat pixels, crops to a per-frame window and reports line length / odd lines.
module cmos_dvp_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int WAIT_FRAMES   = 15,
  parameter int CNT_W         = 12
) (
  input  logic              cmos_pclk_i,
  input  logic              rst_n_i,
  input  logic              cmos_vsync_i,
  input  logic              cmos_href_i,
  input  logic [DATA_W-1:0] cmos_data_i,
  input  logic              cfg_byte_swap_i,
  input  logic [CNT_W-1:0]  cfg_x0_i,
  input  logic [CNT_W-1:0]  cfg_x1_i,
  input  logic [CNT_W-1:0]  cfg_y0_i,
  input  logic [CNT_W-1:0]  cfg_y1_i,
  cmos_dvp_capture_if.master pix,
  output logic              frame_active_o,
  output logic [15:0]       frame_cnt_o,
  output logic [CNT_W-1:0]  line_len_o,
  output logic              err_odd_o
);

  localparam int   PIX_W  = BYTES_PER_PIX * DATA_W;
  localparam int   SKIP_W = $clog2(WAIT_FRAMES + 2);
  localparam logic LAST   = 1'(BYTES_PER_PIX - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_FRAME} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;

  logic               vsync_p0, href_p0, vsync_prev, href_prev;
  logic [DATA_W-1:0]  data_p0;

  logic               swap_sh;
  logic [CNT_W-1:0]   x0_sh, x1_sh, y0_sh, y1_sh;

  logic               phase;
  logic [DATA_W-1:0]  beat0;
  logic [CNT_W-1:0]   x, y;
  logic               sof_pending;
  logic [PIX_W-1:0]   pix_word;

  logic               vld_p1, sof_p1, eol_p1, lend_p1, odd_p1;
  logic [PIX_W-1:0]   data_p1;
  logic [CNT_W-1:0]   len_p1;

  logic frame_start, frame_end, in_frame, beat_en, pix_done, line_end, win_ok, emit;

  // Stage S1: single register on every sensor input, plus previous value for edges
  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vsync_p0   <= 1'b0;
      href_p0    <= 1'b0;
      data_p0    <= '0;
      vsync_prev <= 1'b0;
      href_prev  <= 1'b0;
    end else begin
      vsync_p0   <= cmos_vsync_i;
      href_p0    <= cmos_href_i;
      data_p0    <= cmos_data_i;
      vsync_prev <= vsync_p0;
      href_prev  <= href_p0;
    end
  end

  assign frame_start = vsync_prev & ~vsync_p0;
  assign frame_end   = ~vsync_prev & vsync_p0;
  assign in_frame    = (state_q == ST_FRAME);
  assign beat_en     = in_frame & href_p0;
  assign pix_done    = beat_en & (phase == LAST);
  // A line cut by the frame end is abandoned rather than reported
  assign line_end    = in_frame & href_prev & ~href_p0 & ~frame_end;
  assign win_ok      = (x >= x0_sh) && (x <= x1_sh) && (y >= y0_sh) && (y <= y1_sh);
  assign emit        = pix_done & win_ok;

  generate
    if (BYTES_PER_PIX == 2) begin : g_two_beat
      always_comb pix_word = swap_sh ? {data_p0, beat0} : {beat0, data_p0};
    end else begin : g_one_beat
      always_comb pix_word = data_p0;
    end
  endgenerate

  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAIT;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    case (state_q)
      ST_WAIT: if (frame_start) begin
        if (skip_q == SKIP_W'(WAIT_FRAMES)) state_d = ST_FRAME;
        else                                skip_d  = skip_q + 1'b1;
      end
      ST_IDLE:  if (frame_start) state_d = ST_IDLE == ST_IDLE ? ST_FRAME : ST_IDLE;
      ST_FRAME: if (frame_end)   state_d = ST_IDLE;
      default:  state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      swap_sh     <= 1'b0;
      x0_sh       <= '0;
      x1_sh       <= '0;
      y0_sh       <= '0;
      y1_sh       <= '0;
      frame_cnt_o <= '0;
      phase       <= 1'b0;
      beat0       <= '0;
      x           <= '0;
      y           <= '0;
      sof_pending <= 1'b0;
    end else begin
      if (frame_start) begin
        swap_sh     <= cfg_byte_swap_i;
        x0_sh       <= cfg_x0_i;
        x1_sh       <= cfg_x1_i;
        y0_sh       <= cfg_y0_i;
        y1_sh       <= cfg_y1_i;
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      if (!beat_en || phase == LAST) phase <= 1'b0;
      else                           phase <= phase + 1'b1;
      if (beat_en && phase == 1'b0) beat0 <= data_p0;
      if (frame_start || line_end) x <= '0;
      else if (pix_done)           x <= sat_inc(x);
      if (frame_start)   y <= '0;
      else if (line_end) y <= sat_inc(y);
      if (frame_start) sof_pending <= 1'b1;
      else if (emit)   sof_pending <= 1'b0;
    end
  end

  // Stage p1: pixel / line-end events qualified against the shadowed window
  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1  <= 1'b0;
      sof_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      data_p1 <= '0;
      lend_p1 <= 1'b0;
      odd_p1  <= 1'b0;
      len_p1  <= '0;
    end else begin
      vld_p1  <= emit;
      sof_p1  <= emit & sof_pending;
      eol_p1  <= emit & (x == x1_sh);
      if (emit) data_p1 <= pix_word;
      lend_p1 <= line_end;
      odd_p1  <= line_end & (phase != 1'b0);
      if (line_end) len_p1 <= x;
    end
  end

  // Stage p2: registered outputs
  always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pix.pix_valid_o <= 1'b0;
      pix.pix_sof_o   <= 1'b0;
      pix.pix_eol_o   <= 1'b0;
      pix.pix_data_o  <= '0;
      err_odd_o       <= 1'b0;
      line_len_o      <= '0;
      frame_active_o  <= 1'b0;
    end else begin
      pix.pix_valid_o <= vld_p1;
      pix.pix_sof_o   <= sof_p1;
      pix.pix_eol_o   <= eol_p1;
      if (vld_p1) pix.pix_data_o <= data_p1;
      err_odd_o       <= odd_p1;
      if (lend_p1) line_len_o <= len_p1;
      frame_active_o  <= in_frame;
    end
  end

endmodule
